beatmap_note_queue: RTL and testbench
=====================================

BEATMAP_NOTE_QUEUE -- requirements
Module: beatmap_note_queue

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameters (one per line):
  BASE  180  data code of lane 0
  STEP  4  code spacing between lanes, power of two
  LANES  5  number of lanes (codes 180..196)
  DEPTH  8  note FIFO depth, power of two
REQ-003 Ports (one per line):
  clk  in  1  rising-edge clock
  resetn  in  1  synchronous active-low reset
  data_en  in  1  data word valid this cycle
  data  in  8  beatmap code from the data generator
  beat_tick  in  1  one-cycle beat strobe
  note_ready  in  1  downstream accepts the presented note
  note_valid  out  1  note presented
  note_lane  out  3  lane index of the presented note
  fifo_count  out  4  occupancy, 0..DEPTH
  overflow  out  1  sticky: a valid word was dropped because the FIFO was full
  drop_cnt  out  8  illegal-code count (NOTE_STATS_EN only)
  ovf_cnt  out  8  overflow-drop count (NOTE_STATS_EN only)

Function
REQ-004 SHALL treat a word as legal iff BASE <= data <= BASE+STEP*(LANES-1) and (data-BASE) mod STEP == 0; its lane is (data-BASE)/STEP, computed by shift.
REQ-005 SHALL write a legal word's lane into the FIFO in the data_en cycle; fifo_count updates next edge.
REQ-006 SHALL discard illegal words silently; the FIFO is unchanged.
REQ-007 SHALL drop a legal word when the FIFO is full and no pop occurs that cycle, and SHALL set overflow, which holds until reset.
REQ-008 SHALL accept the push when full with a simultaneous pop; fifo_count stays DEPTH.
REQ-009 SHALL leave fifo_count unchanged on a simultaneous push and pop when not full.
REQ-010 FSM states WAIT and SHOW; reset enters WAIT.
REQ-011 WAIT: beat_tick with fifo_count>0 pops the head into note_lane, goes to SHOW; note_valid=1 the next cycle (1-cycle latency).
REQ-012 WAIT: beat_tick with FIFO empty is ignored; remains in WAIT.
REQ-013 SHOW: note_valid=1 and note_lane stable until note_ready=1, then returns to WAIT; note_valid=0 the next cycle.
REQ-014 SHOW: beat_tick is ignored and not queued, including when coincident with note_ready.
REQ-015 An empty FIFO with push and beat_tick in the same cycle SHALL NOT pop; the note is available from the next beat.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL NOT exceed DEPTH or underflow.

Reset
REQ-017 resetn=0 at an edge SHALL clear note_valid, note_lane, fifo_count, pointers, overflow and counters, and SHALL enter WAIT, including mid-SHOW.
REQ-018 SHALL ignore data_en, beat_tick and note_ready while resetn=0.

Configuration
REQ-019 Macro NOTE_STATS_EN defined: drop_cnt counts illegal words and ovf_cnt counts overflow drops; both saturate at 255.
REQ-020 Macro NOTE_STATS_EN undefined: drop_cnt and ovf_cnt ports and logic are absent; all other behaviour is identical.

Structure
REQ-021 Shared package beatmap_pkg SHALL hold BASE, STEP, LANES, DEPTH defaults, the lane-index type and the FSM state enum.
REQ-022 FIFO storage and pointers SHALL be sub-module note_fifo (push, pop, full, empty, count); decode, FSM and counters are in the top.

Verification
REQ-023 Scenario: reset, then data_en=1 with data 180,184,188,192,196 on consecutive cycles -> fifo_count=5, overflow=0.
REQ-024 Scenario: then beat_tick pulse with note_ready=1 -> note_valid=1 for one cycle, note_lane=0, fifo_count=4; four more ticks -> lanes 1,2,3,4.
REQ-025 Scenario: data 181, 200, 176 with data_en=1 -> fifo_count unchanged; drop_cnt=3 (NOTE_STATS_EN).
REQ-026 Scenario: 10 legal words with no beats -> fifo_count=8, overflow=1, ovf_cnt=2; full push with beat pop in WAIT -> count stays 8.
REQ-027 Scenario: note_ready=0 for 6 cycles in SHOW with 3 beat_ticks -> note_lane held, one note consumed after ready, count decremented once.
REQ-028 Scenario: resetn=0 for one edge during SHOW with 4 queued -> note_valid=0, fifo_count=0, overflow=0, state WAIT.

Source files
------------

// File: rtl/beatmap_pkg.sv
// Shared defaults and types for the beatmap note queue: lane/code geometry,
// FIFO depth, lane-index type and display FSM states.
package beatmap_pkg;
  localparam int DEF_BASE  = 180;
  localparam int DEF_STEP  = 4;
  localparam int DEF_LANES = 5;
  localparam int DEF_DEPTH = 8;

  localparam int LANE_W = $clog2(DEF_LANES);

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_SHOW = 1'b1
  } state_t;
endpackage

// File: rtl/note_fifo.sv
// Circular note FIFO with wrapping pointers and saturating occupancy; push when
// full is honoured only alongside a pop, pop when empty is ignored.
module note_fifo import beatmap_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic          i_pop,
  input  lane_t         i_wdata,
  output lane_t         o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  lane_t         r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/beatmap_note_queue.sv
// Decodes beatmap codes into lane notes, queues them, and presents one note per
// beat until accepted. Define NOTE_STATS_EN to add drop_cnt/ovf_cnt counters.
module beatmap_note_queue import beatmap_pkg::*; #(
  parameter int BASE  = DEF_BASE,
  parameter int STEP  = DEF_STEP,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         data_en,
  input  logic [7:0]                   data,
  input  logic                         beat_tick,
  input  logic                         note_ready,
  output logic                         note_valid,
  output lane_t                        note_lane,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
`ifdef NOTE_STATS_EN
  ,
  output logic [7:0]                   drop_cnt,
  output logic [7:0]                   ovf_cnt
`endif
);
  localparam logic [7:0] LO  = 8'(BASE);
  localparam logic [7:0] HI  = 8'(BASE + STEP * (LANES - 1));
  localparam logic [7:0] MSK = 8'(STEP - 1);
  localparam int         SH  = $clog2(STEP);

  logic [7:0] w_off;
  logic       w_legal, w_full, w_empty, w_pop, w_push, w_ovf_drop;
  lane_t      w_lane, w_head;
  state_t     r_state;
  logic       r_note_valid, r_overflow;
  lane_t      r_note_lane;

  assign w_off   = data - LO;
  assign w_legal = (data >= LO) && (data <= HI) && ((w_off & MSK) == 8'd0);
  assign w_lane  = lane_t'(w_off >> SH);

  // Only a beat in WAIT with something queued pops; a same-cycle push into an
  // empty FIFO is not visible until the next beat.
  assign w_pop      = (r_state == ST_WAIT) && beat_tick && !w_empty;
  assign w_push     = data_en && w_legal;
  assign w_ovf_drop = w_push && w_full && !w_pop;

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_lane),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_WAIT;
      r_note_valid <= 1'b0;
      r_note_lane  <= '0;
    end else begin
      case (r_state)
        ST_WAIT: if (w_pop) begin
          r_note_lane  <= w_head;
          r_note_valid <= 1'b1;
          r_state      <= ST_SHOW;
        end
        ST_SHOW: if (note_ready) begin
          r_note_valid <= 1'b0;
          r_state      <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)         r_overflow <= 1'b0;
    else if (w_ovf_drop) r_overflow <= 1'b1;
  end

  assign note_valid = r_note_valid;
  assign note_lane  = r_note_lane;
  assign overflow   = r_overflow;

`ifdef NOTE_STATS_EN
  logic [7:0] r_drop_cnt, r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_drop_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (data_en && !w_legal && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_ovf_drop && r_ovf_cnt != 8'hFF)           r_ovf_cnt  <= r_ovf_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign ovf_cnt  = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_beatmap_note_queue.sv
// Directed bench for beatmap_note_queue: decode, queueing, beat/ready handshake,
// overflow, wrap and mid-SHOW reset, with hand-computed expectations.
module tb_beatmap_note_queue;
  logic       clk = 1'b0;
  logic       resetn, data_en, beat_tick, note_ready;
  logic [7:0] data;
  logic       note_valid, overflow;
  logic [2:0] note_lane;
  logic [3:0] fifo_count;
`ifdef NOTE_STATS_EN
  logic [7:0] drop_cnt, ovf_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  beatmap_note_queue dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_en    (data_en),
    .data       (data),
    .beat_tick  (beat_tick),
    .note_ready (note_ready),
    .note_valid (note_valid),
    .note_lane  (note_lane),
    .fifo_count (fifo_count),
    .overflow   (overflow)
`ifdef NOTE_STATS_EN
    ,
    .drop_cnt   (drop_cnt),
    .ovf_cnt    (ovf_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic rdy);
    beat_tick  = 1'b1;
    note_ready = rdy;
    step();
    beat_tick  = 1'b0;
  endtask

  initial begin
    logic [7:0] bad [3];
    logic [2:0] exp_lane [3];
    bad[0] = 8'd181; bad[1] = 8'd200; bad[2] = 8'd176;
    exp_lane[0] = 3'd2; exp_lane[1] = 3'd3; exp_lane[2] = 3'd4;

    resetn = 1'b0; data_en = 1'b0; data = '0; beat_tick = 1'b0; note_ready = 1'b0;
    #1;
    step(); step();
    chk("rst_valid", note_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf",   overflow,   0);
    resetn = 1'b1;

    // Every legal code, one per cycle.
    for (int i = 0; i < 5; i++) begin
      data_en = 1'b1; data = 8'(180 + 4 * i);
      step();
    end
    data_en = 1'b0;
    chk("fill5_count", fifo_count, 5);
    chk("fill5_ovf",   overflow,   0);

    for (int i = 0; i < 5; i++) begin
      beat(1'b1);
      chk($sformatf("pop%0d_valid", i), note_valid, 1);
      chk($sformatf("pop%0d_lane", i),  note_lane,  i);
      chk($sformatf("pop%0d_count", i), fifo_count, 4 - i);
      step();
      chk($sformatf("pop%0d_clear", i), note_valid, 0);
    end

    beat(1'b1);
    chk("empty_tick_valid", note_valid, 0);
    chk("empty_tick_count", fifo_count, 0);

    for (int i = 0; i < 3; i++) begin
      data_en = 1'b1; data = bad[i];
      step();
    end
    data_en = 1'b0;
    chk("illegal_count", fifo_count, 0);
`ifdef NOTE_STATS_EN
    chk("drop_cnt", drop_cnt, 3);
`endif

    // 10 legal words into 8 slots; last two (lanes 3,4) dropped. Pointers wrap here.
    for (int i = 0; i < 10; i++) begin
      data_en = 1'b1; data = 8'(180 + 4 * (i % 5));
      step();
    end
    data_en = 1'b0;
    chk("full_count", fifo_count, 8);
    chk("full_ovf",   overflow,   1);
`ifdef NOTE_STATS_EN
    chk("ovf_cnt", ovf_cnt, 2);
`endif

    // Full push with beat pop: queue 0,1,2,3,4,0,1,2 -> 1,2,3,4,0,1,2,4.
    data_en = 1'b1; data = 8'd196;
    beat(1'b1);
    data_en = 1'b0;
    chk("fullpp_count", fifo_count, 8);
    chk("fullpp_lane",  note_lane,  0);
    chk("fullpp_valid", note_valid, 1);
    step();
    chk("fullpp_clear", note_valid, 0);
    chk("ovf_sticky",   overflow,   1);

    // Stall in SHOW with extra beats.
    beat(1'b0);
    chk("stall_lane0",  note_lane,  1);
    chk("stall_count0", fifo_count, 7);
    for (int c = 0; c < 6; c++) begin
      beat_tick = (c % 2 == 0);
      step();
      chk($sformatf("stall%0d_valid", c), note_valid, 1);
      chk($sformatf("stall%0d_lane", c),  note_lane,  1);
      chk($sformatf("stall%0d_count", c), fifo_count, 7);
    end
    beat(1'b1);  // beat coincident with ready is ignored
    chk("release_valid", note_valid, 0);
    chk("release_count", fifo_count, 7);
    step();
    chk("release_idle", note_valid, 0);

    // Pop lanes 2,3 then hold lane 4 in SHOW with 4 queued.
    for (int i = 0; i < 3; i++) begin
      beat(i < 2);
      chk($sformatf("drain%0d_lane", i),  note_lane,  exp_lane[i]);
      chk($sformatf("drain%0d_count", i), fifo_count, 6 - i);
      if (i < 2) step();
    end
    chk("show_valid", note_valid, 1);

    // Reset mid-SHOW, with inputs active that must be ignored.
    resetn = 1'b0; data_en = 1'b1; data = 8'd180; beat_tick = 1'b1; note_ready = 1'b1;
    step();
    resetn = 1'b1; data_en = 1'b0; beat_tick = 1'b0;
    chk("midrst_valid", note_valid, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ovf",   overflow,   0);
    chk("midrst_lane",  note_lane,  0);

    // Push and beat into an empty FIFO: no pop this cycle.
    data_en = 1'b1; data = 8'd188;
    beat(1'b1);
    data_en = 1'b0;
    chk("pushtick_valid", note_valid, 0);
    chk("pushtick_count", fifo_count, 1);
    beat(1'b1);
    chk("next_beat_valid", note_valid, 1);
    chk("next_beat_lane",  note_lane,  2);
    chk("next_beat_count", fifo_count, 0);
    step();
    chk("next_beat_clear", note_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end
endmodule
